// File: rtl/bus_pkg.sv
// Shared types and constants for the STB/WE/ACK bus initiator.
package bus_pkg;

    localparam int BUS_AW          = 32;
    localparam int BUS_DW          = 32;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating STB-cycle counter; expired flags the TIMEOUT-th enabled cycle.
module bus_timeout_ctr
    import bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The count holds at LAST once expired, so it can never wrap.
    assign expired = enable && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bus_master.sv
// Single-outstanding STB/WE/ACK bus initiator with a bounded ACK timeout.
module bus_master
    import bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              req_we,
    input  logic [BUS_AW-1:0] req_addr,
    input  logic [BUS_DW-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [BUS_DW-1:0] rdata,
    output logic              STB,
    output logic              WE,
    output logic [BUS_AW-1:0] ADR,
    output logic [BUS_DW-1:0] DAT_O,
    input  logic [BUS_DW-1:0] DAT_I,
    input  logic              ACK
);

    bus_state_e        state_q, state_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [BUS_AW-1:0] adr_q, adr_d;
    logic [BUS_DW-1:0] dato_q, dato_d;
    logic [BUS_DW-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              expired;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == IDLE),
        .enable  (state_q == REQ),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dato_d  = dato_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    stb_d   = 1'b1;
                    we_d    = req_we;
                    adr_d   = req_addr;
                    dato_d  = req_wdata;
                    state_d = REQ;
                end
            end
            REQ: begin
                // ACK is checked first so a last-cycle ACK still succeeds.
                if (ACK) begin
                    stb_d  = 1'b0;
                    done_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = DAT_I;
                    end
                    state_d = RESP;
                end else if (expired) begin
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                stb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dato_q  <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dato_q  <= dato_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign STB   = stb_q;
    assign WE    = we_q;
    assign ADR   = adr_q;
    assign DAT_O = dato_q;

endmodule

// File: tb/tb_bus_master.sv
// Self-checking bench for bus_master: vector table, randomized accesses, corner sequences.
module tb_bus_master;

    localparam int T = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        req       = 1'b0;
    logic        req_we    = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] DAT_I     = '0;
    logic        ACK       = 1'b0;
    logic        busy, done, err, STB, WE;
    logic [31:0] rdata, ADR, DAT_O;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rdata = '0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] dat;
        int          exp_stb;
        int          exp_done;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    bus_master #(.TIMEOUT(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .STB       (STB),
        .WE        (WE),
        .ADR       (ADR),
        .DAT_O     (DAT_O),
        .DAT_I     (DAT_I),
        .ACK       (ACK)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one access with a slave that ACKs on STB cycle waits+1, then checks it.
    task automatic run_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int waits, input logic [31:0] dat,
                              input int e_stb, input int e_done, input logic e_err,
                              input logic [31:0] e_rdata);
        int          stb_len;
        int          done_at;
        logic        err_seen;
        logic [31:0] rd_seen;
        logic        bus_ok;
        logic        busy_ok;
        stb_len  = 0;
        done_at  = 0;
        err_seen = 1'b0;
        rd_seen  = '0;
        bus_ok   = 1'b1;
        busy_ok  = 1'b1;
        req       = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        req       = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        for (int c = 1; c <= 20 && done_at == 0; c++) begin
            ACK = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (STB) begin
                stb_len++;
                if (ADR !== addr || WE !== we || (we && DAT_O !== wdata)) bus_ok = 1'b0;
                ACK   = (stb_len == waits + 1);
                DAT_I = ACK ? dat : $urandom;
            end
            if (done) begin
                done_at  = c;
                err_seen = err;
                rd_seen  = rdata;
            end else begin
                @(posedge clk); #1;
            end
        end
        ACK = 1'b0;
        chk({tag, " done_seen"}, 32'(done_at != 0), 32'd1);
        chk({tag, " stb_cycles"}, stb_len, e_stb);
        chk({tag, " done_cycle"}, done_at, e_done);
        chk({tag, " err"}, err_seen, e_err);
        chk({tag, " rdata"}, rd_seen, e_rdata);
        chk({tag, " bus_stable"}, bus_ok, 1'b1);
        chk({tag, " busy_during"}, busy_ok, 1'b1);
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, done, 1'b0);
        chk({tag, " err_pulse"}, err, 1'b0);
        chk({tag, " busy_after"}, busy, 1'b0);
        $display("txn %s we=%0b addr=%08h waits=%0d stb=%0d done@%0d err=%0b rdata=%08h",
                 tag, we, addr, waits, stb_len, done_at, err_seen, rd_seen);
    endtask

    initial begin
        int          stbn;
        int          dn;
        int          k;
        logic        adr_ok;
        logic [31:0] saved_adr;
        logic        r_we;
        logic [31:0] r_addr, r_wdata, r_dat;
        int          r_waits, e_stb, e_done;
        logic        e_err;

        vecs[0] = '{1'b1, 32'hF000_0000, 32'h0000_1234, 0,  32'h0,         1, 2, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         3,  32'hDEAD_BEEF, 4, 5, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,         99, 32'h1111_1111, 4, 5, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 32'h0000_0030, 32'h55AA_55AA, 1,  32'h0,         2, 3, 1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 32'h0000_0040, 32'h0,         0,  32'h1234_5678, 1, 2, 1'b0, 32'h1234_5678};
        vecs[5] = '{1'b1, 32'h0000_0050, 32'h0BAD_C0DE, 4,  32'h0,         4, 5, 1'b1, 32'h1234_5678};
        vecs[6] = '{1'b0, 32'h0000_0060, 32'h0,         3,  32'hCAFE_F00D, 4, 5, 1'b0, 32'hCAFE_F00D};
        vecs[7] = '{1'b0, 32'h0000_0070, 32'h0,         2,  32'h00C0_FFEE, 3, 4, 1'b0, 32'h00C0_FFEE};

        // Reset values
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk("rst STB", STB, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst WE", WE, 1'b0);
        chk("rst ADR", ADR, 32'h0);
        chk("rst DAT_O", DAT_O, 32'h0);
        chk("rst rdata", rdata, 32'h0);

        for (int i = 0; i < 8; i++) begin
            run_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                       vecs[i].waits, vecs[i].dat, vecs[i].exp_stb, vecs[i].exp_done,
                       vecs[i].exp_err, vecs[i].exp_rdata);
            model_rdata = vecs[i].exp_rdata;
        end

        // Randomized accesses against the reference timing/data model
        for (int i = 0; i < 40; i++) begin
            r_we    = 1'($urandom);
            r_addr  = $urandom;
            r_wdata = $urandom;
            r_dat   = $urandom;
            r_waits = $urandom_range(0, 6);
            if (r_waits + 1 <= T) begin
                e_stb  = r_waits + 1;
                e_done = r_waits + 2;
                e_err  = 1'b0;
                if (!r_we) model_rdata = r_dat;
            end else begin
                e_stb  = T;
                e_done = T + 1;
                e_err  = 1'b1;
            end
            run_access($sformatf("rnd%0d", i), r_we, r_addr, r_wdata, r_waits, r_dat,
                       e_stb, e_done, e_err, model_rdata);
        end

        // req pulsed during REQ and RESP must be ignored
        req       = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'hA000_0000;
        req_wdata = 32'h0;
        @(posedge clk); #1;
        stbn   = 0;
        dn     = 0;
        k      = 0;
        adr_ok = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            req      = (c == 2 || c == 4);
            req_addr = 32'hBBBB_0000 + 32'(c);
            ACK      = 1'b0;
            if (STB) begin
                k++;
                stbn++;
                if (ADR !== 32'hA000_0000) adr_ok = 1'b0;
                ACK   = (k == 3);
                DAT_I = 32'h1111_2222;
            end
            if (done) dn++;
            @(posedge clk); #1;
        end
        ACK = 1'b0;
        req = 1'b0;
        model_rdata = 32'h1111_2222;
        chk("busyreq stb_cycles", stbn, 3);
        chk("busyreq done_count", dn, 1);
        chk("busyreq adr", adr_ok, 1'b1);
        chk("busyreq rdata", rdata, model_rdata);
        $display("txn busyreq stb=%0d dones=%0d rdata=%08h", stbn, dn, rdata);

        // Spurious ACK while idle
        saved_adr = ADR;
        for (int c = 0; c < 3; c++) begin
            ACK   = 1'b1;
            DAT_I = $urandom;
            @(posedge clk); #1;
            chk("idleack STB", STB, 1'b0);
            chk("idleack done", done, 1'b0);
            chk("idleack busy", busy, 1'b0);
        end
        ACK = 1'b0;
        chk("idleack rdata", rdata, model_rdata);
        chk("idleack ADR", ADR, saved_adr);
        $display("txn idleack rdata=%08h adr=%08h", rdata, ADR);

        // Reset in the second REQ cycle
        req       = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'hC000_0000;
        req_wdata = 32'h7777_8888;
        @(posedge clk); #1;
        req = 1'b0;
        chk("midrst stb_c1", STB, 1'b1);
        @(posedge clk); #1;
        chk("midrst stb_c2", STB, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_rdata = '0;
        chk("midrst STB", STB, 1'b0);
        chk("midrst busy", busy, 1'b0);
        chk("midrst done", done, 1'b0);
        chk("midrst err", err, 1'b0);
        chk("midrst WE", WE, 1'b0);
        chk("midrst ADR", ADR, 32'h0);
        chk("midrst DAT_O", DAT_O, 32'h0);
        chk("midrst rdata", rdata, 32'h0);
        stbn = 0;
        dn   = 0;
        for (int c = 0; c < 6; c++) begin
            if (STB) stbn++;
            if (done) dn++;
            @(posedge clk); #1;
        end
        chk("midrst no_stb", stbn, 0);
        chk("midrst no_done", dn, 0);
        $display("txn midrst stb_after=%0d done_after=%0d", stbn, dn);

        run_access("postrst", 1'b0, 32'h0000_0100, 32'h0, 1, 32'h0F0F_0F0F,
                   2, 3, 1'b0, 32'h0F0F_0F0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
